if_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit for the pipelined core; successor to the single-cycle fetch path. Holds the PC, computes sequential and redirect next-PC, drives a one-cycle-latency instruction memory port, and buffers fetched instructions in a QDEPTH-entry queue. Decode consumes the queue through a valid/ready handshake. A redirect flushes all buffered and in-flight instructions.

---
 rtl/if_fetch_queue_if.sv | 31 +++
 rtl/if_fetch_queue.sv | 117 +++++++++++
 tb/tb_if_fetch_queue.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_if.sv
// Bundle of redirect, instruction-memory and decode-side handshake signals for if_fetch_queue.
interface if_fetch_queue_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              redir_valid;
    logic              redir_sel;
    logic [ADDR_W-1:0] redir_base;
    logic [31:0]       redir_imm;
    logic [ADDR_W-1:0] redir_alu;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_pc4;
    logic              misalign_err;

    modport master (
        input  redir_valid, redir_sel, redir_base, redir_imm, redir_alu,
        input  imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4, misalign_err
    );

    modport slave (
        output redir_valid, redir_sel, redir_base, redir_imm, redir_alu,
        output imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_pc4, misalign_err
    );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: PC, one-cycle imem port and a QDEPTH-entry instruction queue to decode.
// Optional IF_MISALIGN_CHK_EN: misaligned redirects halt fetch and pulse misalign_err.
module if_fetch_queue #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int unsigned       QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_queue_if.master bus
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 2;

    typedef struct packed {
        logic [31:0]       inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    entry_t            q [QDEPTH];
    logic [PTR_W:0]    wptr;
    logic [PTR_W:0]    rptr;
    logic [PTR_W:0]    occ;
    logic [CNT_W-1:0]  pending;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              run;
    logic              pop;
    logic              issue;
    logic              target_ok;
    logic [ADDR_W-1:0] target_raw;
    logic [ADDR_W-1:0] target;
    entry_t            head;

    assign occ        = wptr - rptr;
    assign head       = q[rptr[PTR_W-1:0]];
    assign pop        = bus.out_valid & bus.out_ready;
    // Slots already claimed once this cycle's pop leaves: stored entries plus the one in flight.
    assign pending    = CNT_W'(occ) + CNT_W'(inflight) - CNT_W'(pop);
    assign issue      = rst_n & run & ~bus.redir_valid & (pending < CNT_W'(QDEPTH));
    assign target_raw = bus.redir_sel ? (bus.redir_alu & ~ADDR_W'(1))
                                      : (bus.redir_base + bus.redir_imm[ADDR_W-1:0]);

    assign bus.imem_req  = issue;
    assign bus.imem_addr = pc;
    assign bus.out_valid = (occ != '0) & ~bus.redir_valid;
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
    assign bus.out_pc4   = head.pc + ADDR_W'(4);

`ifdef IF_MISALIGN_CHK_EN
    typedef enum logic {RUN, HALT} state_t;

    state_t state;
    logic   misalign_q;

    assign target_ok        = (target_raw[1:0] == 2'b00);
    assign target           = target_raw;
    assign run              = (state == RUN);
    assign bus.misalign_err = misalign_q;

    // Misaligned redirect parks the unit in HALT until an aligned redirect arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bus.redir_valid & ~target_ok;
            if (bus.redir_valid) begin
                state <= target_ok ? RUN : HALT;
            end
        end
    end
`else
    assign target_ok        = 1'b1;
    assign target           = target_raw & ~ADDR_W'(3);
    assign run              = 1'b1;
    assign bus.misalign_err = 1'b0;
`endif

    // PC, in-flight tracking and queue. The response presented during a redirect cycle is
    // discarded at the flushing edge, so nothing fetched before the redirect survives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            wptr        <= '0;
            rptr        <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q[i] <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(4);
                inflight_pc <= pc;
            end
            if (bus.redir_valid) begin
                wptr <= '0;
                rptr <= '0;
                if (target_ok) begin
                    pc <= target;
                end
            end else begin
                if (inflight) begin
                    q[wptr[PTR_W-1:0]] <= '{inst: bus.imem_rdata, pc: inflight_pc};
                    wptr               <= wptr + (PTR_W+1)'(1);
                end
                if (pop) begin
                    rptr <= rptr + (PTR_W+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus randomized redirects/back-pressure.
module tb_if_fetch_queue;
    localparam int unsigned  ADDR_W   = 32;
    localparam int unsigned  QDEPTH   = 4;
    localparam logic [31:0]  RESET_PC = 32'h0000_0100;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state
    logic [31:0] exp_q[$];
    logic [31:0] next_fetch  = RESET_PC;
    int          outstanding = 0;
    bit          req_prev    = 0;
    bit          halted      = 0;
    bit          mis_next    = 0;
    bit          mis_exp     = 0;
    int          pops_total  = 0;

    if_fetch_queue_if #(.ADDR_W(ADDR_W)) intf ();

    if_fetch_queue #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (intf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Instruction memory: data for the requested address appears in the following cycle.
    always @(posedge clk) begin
        intf.imem_rdata <= intf.imem_req ? hash(intf.imem_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        exp_q.delete();
        exp_q.push_back(RESET_PC);
        next_fetch  = RESET_PC;
        outstanding = 0;
        req_prev    = 0;
        halted      = 0;
        mis_next    = 0;
        mis_exp     = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic redirect(input logic sel, input logic [31:0] base, input logic [31:0] imm,
                            input logic [31:0] alu);
        logic [31:0] t;
        intf.redir_valid = 1'b1;
        intf.redir_sel   = sel;
        intf.redir_base  = base;
        intf.redir_imm   = imm;
        intf.redir_alu   = alu;
        t = sel ? (alu & ~32'h1) : (base + imm);
        exp_q.delete();
        outstanding = 0;
`ifdef IF_MISALIGN_CHK_EN
        if (t[1:0] != 2'b00) begin
            halted   = 1;
            mis_next = 1;
        end else begin
            halted     = 0;
            exp_q.push_back(t);
            next_fetch = t;
        end
`else
        t[1:0] = 2'b00;
        exp_q.push_back(t);
        next_fetch = t;
`endif
    endtask

    task automatic no_redirect();
        intf.redir_valid = 1'b0;
    endtask

    // Monitor: predicts handshake/request behaviour from occupancy counts and pops the scoreboard.
    initial begin
        logic [31:0] e;
        int          occ_m;
        bit          exp_valid;
        bit          exp_req;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", 32'(intf.out_valid), 32'd0);
                chk("rst_imem_req", 32'(intf.imem_req), 32'd0);
                chk("rst_misalign", 32'(intf.misalign_err), 32'd0);
                chk("rst_out_pc", intf.out_pc, 32'd0);
                chk("rst_out_inst", intf.out_inst, 32'd0);
                chk("rst_out_pc4", intf.out_pc4, 32'd4);
            end else begin
                occ_m     = outstanding - (req_prev ? 1 : 0);
                exp_valid = (occ_m > 0) && !intf.redir_valid;
                chk("out_valid", 32'(intf.out_valid), 32'(exp_valid));
                if (intf.out_valid && intf.out_ready) begin
                    pops_total++;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL unexpected_pop at %0t: got pc 0x%08h expected no instruction",
                                 $time, intf.out_pc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_pc", intf.out_pc, e);
                        chk("out_inst", intf.out_inst, hash(e));
                        chk("out_pc4", intf.out_pc4, e + 32'd4);
                        exp_q.push_back(e + 32'd4);
                    end
                    outstanding--;
                end
                exp_req = !halted && !intf.redir_valid && (outstanding < QDEPTH);
                chk("imem_req", 32'(intf.imem_req), 32'(exp_req));
                if (intf.imem_req) begin
                    chk("imem_addr", intf.imem_addr, next_fetch);
                    next_fetch = next_fetch + 32'd4;
                    outstanding++;
                end
                req_prev = intf.imem_req;
                chk("misalign_err", 32'(intf.misalign_err), 32'(mis_exp));
                mis_exp  = mis_next;
                mis_next = 0;
            end
        end
    end

    // Stimulus
    initial begin
        int cnt;
        int k;
        logic [31:0] imm;
        logic [31:0] alu;
        rst_n            = 1'b0;
        intf.redir_valid = 1'b0;
        intf.redir_sel   = 1'b0;
        intf.redir_base  = '0;
        intf.redir_imm   = '0;
        intf.redir_alu   = '0;
        intf.out_ready   = 1'b1;

        // Reset release and first fetches with full throughput
        do_reset();
        @(negedge clk);
        chk("t1_req_c1", 32'(intf.imem_req), 32'd1);
        chk("t1_addr_c1", intf.imem_addr, 32'h100);
        step(); @(negedge clk);
        chk("t1_addr_c2", intf.imem_addr, 32'h104);
        step(); @(negedge clk);
        chk("t1_addr_c3", intf.imem_addr, 32'h108);
        chk("t1_valid_c3", 32'(intf.out_valid), 32'd1);
        chk("t1_pc_c3", intf.out_pc, 32'h100);
        chk("t1_pc4_c3", intf.out_pc4, 32'h104);
        for (int i = 0; i < 5; i++) begin
            step(); @(negedge clk);
            chk("t1_sustained_valid", 32'(intf.out_valid), 32'd1);
        end

        // Back-pressure fills the queue, then drains in order
        step();
        intf.out_ready = 1'b0;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt += int'(intf.imem_req);
            step();
        end
        chk("t2_req_count", 32'(cnt), 32'd4);
        @(negedge clk);
        chk("t2_req_full", 32'(intf.imem_req), 32'd0);
        chk("t2_head_valid", 32'(intf.out_valid), 32'd1);
        chk("t2_head_pc", intf.out_pc, 32'h100);
        step();
        intf.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_drain_pc", intf.out_pc, 32'h100 + 32'(4 * i));
            step();
        end

        // Branch redirect: base 0x200, imm -8
        redirect(1'b0, 32'h200, 32'hFFFF_FFF8, 32'h0);
        @(negedge clk);
        chk("t3_valid_n", 32'(intf.out_valid), 32'd0);
        step(); no_redirect(); @(negedge clk);
        chk("t3_req_n1", 32'(intf.imem_req), 32'd1);
        chk("t3_addr_n1", intf.imem_addr, 32'h1F8);
        chk("t3_valid_n1", 32'(intf.out_valid), 32'd0);
        step(); @(negedge clk);
        chk("t3_valid_n2", 32'(intf.out_valid), 32'd0);
        step(); @(negedge clk);
        chk("t3_valid_n3", 32'(intf.out_valid), 32'd1);
        chk("t3_pc_n3", intf.out_pc, 32'h1F8);

        // jalr clears bit 0; then two back-to-back redirects
        step(); redirect(1'b1, 32'h0, 32'h0, 32'h301);
        step(); no_redirect(); @(negedge clk);
        chk("t4_jalr_addr", intf.imem_addr, 32'h300);
        repeat (4) step();
        redirect(1'b0, 32'h400, 32'h0, 32'h0);
        step(); redirect(1'b0, 32'h500, 32'h0, 32'h0);
        step(); no_redirect(); @(negedge clk);
        chk("t4_last_wins", intf.imem_addr, 32'h500);
        repeat (5) step();

        // jalr to 0x302: halts with the check enabled, otherwise fetches at 0x300
        redirect(1'b1, 32'h0, 32'h0, 32'h302);
        step(); no_redirect(); @(negedge clk);
`ifdef IF_MISALIGN_CHK_EN
        chk("t5_misalign_pulse", 32'(intf.misalign_err), 32'd1);
        chk("t5_halt_req", 32'(intf.imem_req), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(); @(negedge clk);
            chk("t5_halt_req", 32'(intf.imem_req), 32'd0);
            chk("t5_misalign_low", 32'(intf.misalign_err), 32'd0);
        end
        step(); redirect(1'b0, 32'h40, 32'h0, 32'h0);
        step(); no_redirect(); @(negedge clk);
        chk("t5_resume_addr", intf.imem_addr, 32'h40);
        chk("t5_resume_req", 32'(intf.imem_req), 32'd1);
`else
        chk("t5_forced_addr", intf.imem_addr, 32'h300);
        chk("t5_no_misalign", 32'(intf.misalign_err), 32'd0);
`endif
        repeat (4) step();

        // PC wraps past the top of the address space
        redirect(1'b0, 32'hFFFF_FFF0, 32'h8, 32'h0);
        step(); no_redirect(); @(negedge clk);
        chk("wrap_addr0", intf.imem_addr, 32'hFFFF_FFF8);
        step(); @(negedge clk);
        chk("wrap_addr1", intf.imem_addr, 32'hFFFF_FFFC);
        step(); @(negedge clk);
        chk("wrap_addr2", intf.imem_addr, 32'h0);
        repeat (6) step();

        // Asynchronous reset with three entries queued
        intf.out_ready = 1'b0;
        do_reset();
        repeat (4) step();
        @(negedge clk);
        chk("t6_valid_before", 32'(intf.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_valid_async", 32'(intf.out_valid), 32'd0);
        chk("t6_req_async", 32'(intf.imem_req), 32'd0);
        repeat (2) step();
        rst_n = 1'b1;
        intf.out_ready = 1'b1;
        @(negedge clk);
        chk("t6_restart_req", 32'(intf.imem_req), 32'd1);
        chk("t6_restart_addr", intf.imem_addr, RESET_PC);

        // Randomized redirects and back-pressure
        pops_total = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            intf.out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) begin
                k   = int'($urandom_range(0, 64));
                imm = 32'((k - 32) * 4);
                if ($urandom_range(0, 7) == 0) imm = imm + 32'($urandom_range(1, 3));
                alu = ($urandom & 32'h000F_FFFC) | 32'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) alu = alu | 32'h2;
                redirect(1'($urandom_range(0, 1)), $urandom & 32'h000F_FFFC, imm, alu);
            end else begin
                no_redirect();
            end
        end
        step();
        no_redirect();
        intf.out_ready = 1'b1;
        repeat (10) step();
        chk("random_progress", 32'(pops_total > 200), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
